// File: rtl/motor_seq_ctrl.sv
// Motion sequencer: soft-start ramp, timed hold, ramp-down and coast-down dead time for a PWM motor driver.
// Latency: accept to pwm_enable is one cycle; speed moves one level every RAMP_TICKS ticks.
// Backpressure: cmd_ready only in IDLE with estop low; commands offered while busy are dropped, not queued.
module motor_seq_ctrl #(
   parameter int unsigned TICK_DIV   = 50000,
   parameter int unsigned RAMP_TICKS = 20,
   parameter int unsigned DEAD_TICKS = 100
) (
   input  logic        sclk,
   input  logic        s_rst_n,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic        cmd_dir,
   input  logic [2:0]  cmd_speed,
   input  logic [15:0] cmd_dur,
   input  logic        stop_req,
   input  logic        estop,
   output logic        pwm_enable,
   output logic        pwm_direct,
   output logic [2:0]  pwm_cnt,
   output logic        busy,
   output logic        done,
   output logic        fault
);

   localparam int unsigned PW = (TICK_DIV   > 1) ? $clog2(TICK_DIV)   : 1;
   localparam int unsigned RW = (RAMP_TICKS > 1) ? $clog2(RAMP_TICKS) : 1;
   localparam int unsigned DW = (DEAD_TICKS > 1) ? $clog2(DEAD_TICKS) : 1;

   localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
   localparam logic [RW-1:0] RAMP_LAST  = RW'(RAMP_TICKS - 1);
   localparam logic [DW-1:0] DEAD_LAST  = DW'(DEAD_TICKS - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_RAMP_UP,
      S_RUN,
      S_RAMP_DOWN,
      S_DEAD
   } state_t;

   state_t        state_q,      state_d;
   logic [PW-1:0] presc_q,      presc_d;
   logic [2:0]    cur_speed_q,  cur_speed_d;
   logic [2:0]    tgt_speed_q,  tgt_speed_d;
   logic          dir_q,        dir_d;
   logic [15:0]   dur_cnt_q,    dur_cnt_d;
   logic [RW-1:0] ramp_cnt_q,   ramp_cnt_d;
   logic [DW-1:0] dead_cnt_q,   dead_cnt_d;
   logic          pwm_enable_q, pwm_enable_d;
   logic          done_q,       done_d;
   logic          fault_q,      fault_d;

   logic          tick;
   logic          step_due;

   // Free-running prescaler; its phase is never re-aligned to commands.
   always_comb begin
      tick    = (presc_q == PRESC_LAST);
      presc_d = tick ? '0 : presc_q + PW'(1);
   end

   // Sequencer next state: estop first, then stop_req, then duration expiry, then ramp steps.
   always_comb begin
      state_d      = state_q;
      cur_speed_d  = cur_speed_q;
      tgt_speed_d  = tgt_speed_q;
      dir_d        = dir_q;
      dur_cnt_d    = dur_cnt_q;
      ramp_cnt_d   = ramp_cnt_q;
      dead_cnt_d   = dead_cnt_q;
      pwm_enable_d = pwm_enable_q;
      done_d       = 1'b0;
      fault_d      = fault_q;
      step_due     = tick && (ramp_cnt_q == RAMP_LAST);

      if (estop && (state_q != S_IDLE)) begin
         // Holding estop keeps dead_cnt pinned at 0, so the dead time restarts on release.
         state_d      = S_DEAD;
         cur_speed_d  = 3'd0;
         pwm_enable_d = 1'b0;
         dead_cnt_d   = '0;
         fault_d      = 1'b1;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (cmd_valid && cmd_ready) begin
                  fault_d = 1'b0;
                  if (cmd_speed == 3'd0) begin
                     done_d = 1'b1;
                  end else begin
                     tgt_speed_d  = cmd_speed;
                     dir_d        = cmd_dir;
                     dur_cnt_d    = cmd_dur;
                     ramp_cnt_d   = '0;
                     pwm_enable_d = 1'b1;
                     state_d      = S_RAMP_UP;
                  end
               end
            end
            S_RAMP_UP: begin
               if (stop_req) begin
                  state_d    = S_RAMP_DOWN;
                  ramp_cnt_d = '0;
               end else if (step_due) begin
                  ramp_cnt_d  = '0;
                  cur_speed_d = cur_speed_q + 3'd1;
                  if ((cur_speed_q + 3'd1) == tgt_speed_q) begin
                     state_d = S_RUN;
                  end
               end else if (tick) begin
                  ramp_cnt_d = ramp_cnt_q + RW'(1);
               end
            end
            S_RUN: begin
               // dur_cnt of 0 means continuous: only stop_req leaves RUN.
               if (stop_req) begin
                  state_d    = S_RAMP_DOWN;
                  ramp_cnt_d = '0;
               end else if (tick && (dur_cnt_q != 16'd0)) begin
                  dur_cnt_d = dur_cnt_q - 16'd1;
                  if (dur_cnt_q == 16'd1) begin
                     state_d    = S_RAMP_DOWN;
                     ramp_cnt_d = '0;
                  end
               end
            end
            S_RAMP_DOWN: begin
               // A stop before the first up-step arrives here already at level 0.
               if (cur_speed_q == 3'd0) begin
                  state_d      = S_DEAD;
                  pwm_enable_d = 1'b0;
                  dead_cnt_d   = '0;
               end else if (step_due) begin
                  ramp_cnt_d  = '0;
                  cur_speed_d = cur_speed_q - 3'd1;
                  if (cur_speed_q == 3'd1) begin
                     state_d      = S_DEAD;
                     pwm_enable_d = 1'b0;
                     dead_cnt_d   = '0;
                  end
               end else if (tick) begin
                  ramp_cnt_d = ramp_cnt_q + RW'(1);
               end
            end
            S_DEAD: begin
               // fault doubles as the aborted flag: it is set by estop and cleared on accept.
               if (tick) begin
                  if (dead_cnt_q == DEAD_LAST) begin
                     state_d    = S_IDLE;
                     dead_cnt_d = '0;
                     done_d     = ~fault_q;
                  end else begin
                     dead_cnt_d = dead_cnt_q + DW'(1);
                  end
               end
            end
            default: begin
               state_d      = S_IDLE;
               cur_speed_d  = 3'd0;
               pwm_enable_d = 1'b0;
            end
         endcase
      end
   end

   // State and output registers with synchronous active-low reset.
   always_ff @(posedge sclk) begin
      if (!s_rst_n) begin
         state_q      <= S_IDLE;
         presc_q      <= '0;
         cur_speed_q  <= 3'd0;
         tgt_speed_q  <= 3'd0;
         dir_q        <= 1'b0;
         dur_cnt_q    <= 16'd0;
         ramp_cnt_q   <= '0;
         dead_cnt_q   <= '0;
         pwm_enable_q <= 1'b0;
         done_q       <= 1'b0;
         fault_q      <= 1'b0;
      end else begin
         state_q      <= state_d;
         presc_q      <= presc_d;
         cur_speed_q  <= cur_speed_d;
         tgt_speed_q  <= tgt_speed_d;
         dir_q        <= dir_d;
         dur_cnt_q    <= dur_cnt_d;
         ramp_cnt_q   <= ramp_cnt_d;
         dead_cnt_q   <= dead_cnt_d;
         pwm_enable_q <= pwm_enable_d;
         done_q       <= done_d;
         fault_q      <= fault_d;
      end
   end

   assign cmd_ready  = (state_q == S_IDLE) && !estop;
   assign busy       = (state_q != S_IDLE);
   assign pwm_enable = pwm_enable_q;
   assign pwm_direct = dir_q;
   assign pwm_cnt    = cur_speed_q;
   assign done       = done_q;
   assign fault      = fault_q;

endmodule

// File: tb/tb_motor_seq_ctrl.sv
// Bench for motor_seq_ctrl with TICK_DIV=4, RAMP_TICKS=2, DEAD_TICKS=3.
// Output changes are matched against an expected-event queue with cycle-gap windows.
// IDLE handshake behaviour is checked from a vector table.
module tb_motor_seq_ctrl;

   localparam int TD = 4;
   localparam int RT = 2;
   localparam int DT = 3;

   logic        sclk = 1'b0;
   logic        s_rst_n;
   logic        cmd_valid;
   logic        cmd_ready;
   logic        cmd_dir;
   logic [2:0]  cmd_speed;
   logic [15:0] cmd_dur;
   logic        stop_req;
   logic        estop;
   logic        pwm_enable;
   logic        pwm_direct;
   logic [2:0]  pwm_cnt;
   logic        busy;
   logic        done;
   logic        fault;

   always #5 sclk = ~sclk;

   motor_seq_ctrl #(.TICK_DIV(TD), .RAMP_TICKS(RT), .DEAD_TICKS(DT)) dut (
      .sclk       (sclk),
      .s_rst_n    (s_rst_n),
      .cmd_valid  (cmd_valid),
      .cmd_ready  (cmd_ready),
      .cmd_dir    (cmd_dir),
      .cmd_speed  (cmd_speed),
      .cmd_dur    (cmd_dur),
      .stop_req   (stop_req),
      .estop      (estop),
      .pwm_enable (pwm_enable),
      .pwm_direct (pwm_direct),
      .pwm_cnt    (pwm_cnt),
      .busy       (busy),
      .done       (done),
      .fault      (fault)
   );

   // Expected output change: v = {en, dir, cnt[2:0], done, busy, fault};
   // gap measured from cycle rf, or from the previous change when rf < 0.
   typedef struct {
      string      nm;
      logic [7:0] v;
      int         rf;
      int         gmin;
      int         gmax;
   } exp_t;

   typedef struct {
      string      nm;
      logic       valid;
      logic       dir;
      logic [2:0] speed;
      logic       stop;
      logic       es;
      logic       exp_ready;
      logic [4:0] exp_out;   // {done, busy, en, direct, fault} one edge later
   } vec_t;

   exp_t sb[$];
   int   n_cmp = 0;
   int   n_bad = 0;
   int   cyc = 0;
   bit   mon_on = 1'b0;

   function automatic logic [7:0] obs();
      obs = {pwm_enable, pwm_direct, pwm_cnt, done, busy, fault};
   endfunction

   function automatic void push(string nm, logic en, logic dir, logic [2:0] cnt, logic dn,
                                logic bsy, logic flt, int rf, int gmin, int gmax);
      exp_t e;
      e.nm   = nm;
      e.v    = {en, dir, cnt, dn, bsy, flt};
      e.rf   = rf;
      e.gmin = gmin;
      e.gmax = gmax;
      sb.push_back(e);
   endfunction

   task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h required %0h", nm, got, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(negedge sclk);
         #1;
      end
   endtask

   task automatic wait_sb(input int budget, input string nm);
      for (int i = 0; i < budget && sb.size() != 0; i++) step(1);
      n_cmp++;
      if (sb.size() != 0) begin
         n_bad++;
         $display("FAIL %s: %0d expected events still pending (next %s), required 0", nm, sb.size(), sb[0].nm);
         sb.delete();
      end
   endtask

   task automatic send(input logic d, input logic [2:0] sp, input logic [15:0] du, output int c);
      cmd_valid = 1'b1;
      cmd_dir   = d;
      cmd_speed = sp;
      cmd_dur   = du;
      c         = cyc;
   endtask

   // Cycle counter, read only away from the rising edge.
   initial forever begin
      @(posedge sclk);
      cyc++;
   end

   // Scoreboard monitor: every output change pops and checks one expected event.
   initial begin
      logic [7:0] cur;
      logic [7:0] last_obs;
      int         last_chg;
      int         gap;
      exp_t       e;
      last_obs = 'x;
      last_chg = 0;
      forever begin
         @(negedge sclk);
         cur = obs();
         if (cur !== last_obs) begin
            if (mon_on) begin
               n_cmp++;
               if (sb.size() == 0) begin
                  n_bad++;
                  $display("FAIL unexpected_change: got outputs %b at cycle %0d, required no change", cur, cyc);
               end else begin
                  e   = sb.pop_front();
                  gap = cyc - ((e.rf >= 0) ? e.rf : last_chg);
                  if (cur !== e.v || gap < e.gmin || gap > e.gmax) begin
                     n_bad++;
                     $display("FAIL %s: got outputs %b after %0d cycles, required %b after %0d..%0d cycles",
                              e.nm, cur, gap, e.v, e.gmin, e.gmax);
                  end
               end
            end
            last_chg = cyc;
         end
         last_obs = cur;
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation still running at 100000 ns, required finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      vec_t vt[8];
      int   c0;
      int   c1;
      int   rb;

      vt[0] = '{"idle_quiet",      1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 5'b00000};
      vt[1] = '{"idle_stop",       1'b0, 1'b0, 3'd0, 1'b1, 1'b0, 1'b1, 5'b00000};
      vt[2] = '{"idle_estop",      1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0, 5'b00000};
      vt[3] = '{"idle_estop_cmd",  1'b1, 1'b1, 3'd3, 1'b0, 1'b1, 1'b0, 5'b00000};
      vt[4] = '{"zero_cmd",        1'b1, 1'b1, 3'd0, 1'b0, 1'b0, 1'b1, 5'b10000};
      vt[5] = '{"zero_cmd_stop",   1'b1, 1'b0, 3'd0, 1'b1, 1'b0, 1'b1, 5'b10000};
      vt[6] = '{"idle_after_zero", 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 5'b00000};
      vt[7] = '{"estop_zero_cmd",  1'b1, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0, 5'b00000};

      s_rst_n   = 1'b0;
      cmd_valid = 1'b0;
      cmd_dir   = 1'b0;
      cmd_speed = 3'd0;
      cmd_dur   = 16'd0;
      stop_req  = 1'b0;
      estop     = 1'b0;

      // Reset held for three cycles
      step(3);
      check("reset_outputs", 32'(obs()), 32'h0);
      check("reset_ready", 32'(cmd_ready), 32'h1);
      s_rst_n = 1'b1;
      step(2);

      // IDLE handshake vectors
      for (int i = 0; i < 8; i++) begin
         cmd_valid = vt[i].valid;
         cmd_dir   = vt[i].dir;
         cmd_speed = vt[i].speed;
         cmd_dur   = 16'd7;
         stop_req  = vt[i].stop;
         estop     = vt[i].es;
         #1;
         check({vt[i].nm, "_ready"}, 32'(cmd_ready), 32'(vt[i].exp_ready));
         step(1);
         check({vt[i].nm, "_out"}, 32'({done, busy, pwm_enable, pwm_direct, fault}), 32'(vt[i].exp_out));
      end
      cmd_valid = 1'b0;
      stop_req  = 1'b0;
      estop     = 1'b0;
      step(2);
      mon_on = 1'b1;

      // Normal move dir=1 speed=3 dur=5 with cmd_valid held and payload churning
      send(1'b1, 3'd3, 16'd5, c0);
      push("nm_accept",    1, 1, 3'd0, 0, 1, 0, c0, 1, 1);
      push("nm_step1",     1, 1, 3'd1, 0, 1, 0, -1, 5, 8);
      push("nm_step2",     1, 1, 3'd2, 0, 1, 0, -1, 8, 8);
      push("nm_step3",     1, 1, 3'd3, 0, 1, 0, -1, 8, 8);
      push("nm_down2",     1, 1, 3'd2, 0, 1, 0, -1, 28, 28);  // 20 in RUN + 8 to first down-step
      push("nm_down1",     1, 1, 3'd1, 0, 1, 0, -1, 8, 8);
      push("nm_down0",     0, 1, 3'd0, 0, 1, 0, -1, 8, 8);
      push("nm_done",      0, 1, 3'd0, 1, 0, 0, -1, 12, 12);
      push("nm_done_fall", 0, 1, 3'd0, 0, 0, 0, -1, 1, 1);
      rb = 0;
      for (int i = 0; i < 300 && sb.size() != 0; i++) begin
         step(1);
         if (busy && cmd_ready) rb++;
         if (busy && pwm_enable) begin
            cmd_dir   = 1'b0;
            cmd_speed = 3'($urandom_range(4, 7));
            cmd_dur   = 16'($urandom_range(1, 9));
         end else if (busy) begin
            cmd_valid = 1'b0;
         end
      end
      cmd_valid = 1'b0;
      wait_sb(1, "nm_timeout");
      check("hs_ready_while_busy", 32'(rb), 32'h0);
      step(3);

      // Continuous run at speed 7, stop_req 100 cycles after accept
      send(1'b0, 3'd7, 16'd0, c0);
      push("cr_accept", 1, 0, 3'd0, 0, 1, 0, c0, 1, 1);
      push("cr_step1",  1, 0, 3'd1, 0, 1, 0, -1, 5, 8);
      for (int k = 2; k <= 7; k++) push("cr_step", 1, 0, 3'(k), 0, 1, 0, -1, 8, 8);
      step(1);
      cmd_valid = 1'b0;
      step(99);
      wait_sb(1, "cr_rampup_timeout");
      c1 = cyc;
      stop_req = 1'b1;
      push("cr_down6", 1, 0, 3'd6, 0, 1, 0, c1, 6, 9);
      for (int k = 5; k >= 1; k--) push("cr_down", 1, 0, 3'(k), 0, 1, 0, -1, 8, 8);
      push("cr_down0",     0, 0, 3'd0, 0, 1, 0, -1, 8, 8);
      push("cr_done",      0, 0, 3'd0, 1, 0, 0, -1, 12, 12);
      push("cr_done_fall", 0, 0, 3'd0, 0, 0, 0, -1, 1, 1);
      step(1);
      stop_req = 1'b0;
      wait_sb(200, "cr_rampdown_timeout");
      step(3);

      // stop_req during RAMP_UP at level 2
      send(1'b0, 3'd7, 16'd0, c0);
      push("su_accept", 1, 0, 3'd0, 0, 1, 0, c0, 1, 1);
      push("su_step1",  1, 0, 3'd1, 0, 1, 0, -1, 5, 8);
      push("su_step2",  1, 0, 3'd2, 0, 1, 0, -1, 8, 8);
      step(1);
      cmd_valid = 1'b0;
      wait_sb(40, "su_rampup_timeout");
      c1 = cyc;
      stop_req = 1'b1;
      push("su_down1",     1, 0, 3'd1, 0, 1, 0, c1, 6, 9);
      push("su_down0",     0, 0, 3'd0, 0, 1, 0, -1, 8, 8);
      push("su_done",      0, 0, 3'd0, 1, 0, 0, -1, 12, 12);
      push("su_done_fall", 0, 0, 3'd0, 0, 0, 0, -1, 1, 1);
      step(1);
      stop_req = 1'b0;
      wait_sb(80, "su_rampdown_timeout");
      step(3);

      // Emergency stop in RUN at speed 3, held 10 cycles
      send(1'b1, 3'd3, 16'd0, c0);
      push("es_accept", 1, 1, 3'd0, 0, 1, 0, c0, 1, 1);
      push("es_step1",  1, 1, 3'd1, 0, 1, 0, -1, 5, 8);
      push("es_step2",  1, 1, 3'd2, 0, 1, 0, -1, 8, 8);
      push("es_step3",  1, 1, 3'd3, 0, 1, 0, -1, 8, 8);
      step(1);
      cmd_valid = 1'b0;
      wait_sb(40, "es_rampup_timeout");
      step(4);
      c1 = cyc;
      estop = 1'b1;
      push("es_abort", 0, 1, 3'd0, 0, 1, 1, c1, 1, 1);
      rb = 0;
      for (int i = 0; i < 10; i++) begin
         step(1);
         if (cmd_ready) rb++;
      end
      check("es_ready_while_estop", 32'(rb), 32'h0);
      c1 = cyc;
      estop = 1'b0;
      push("es_idle", 0, 1, 3'd0, 0, 0, 1, c1, 9, 12);
      wait_sb(20, "es_idle_timeout");
      step(20);
      check("es_ready_after", 32'(cmd_ready), 32'h1);

      // Zero-speed command: done next cycle, fault cleared, direction kept
      send(1'b0, 3'd0, 16'd9, c0);
      push("zs_done",      0, 1, 3'd0, 1, 0, 0, c0, 1, 1);
      push("zs_done_fall", 0, 1, 3'd0, 0, 0, 0, -1, 1, 1);
      step(1);
      cmd_valid = 1'b0;
      wait_sb(10, "zs_timeout");
      step(5);

      // Reset asserted mid-RUN
      send(1'b1, 3'd2, 16'd0, c0);
      push("rr_accept", 1, 1, 3'd0, 0, 1, 0, c0, 1, 1);
      push("rr_step1",  1, 1, 3'd1, 0, 1, 0, -1, 5, 8);
      push("rr_step2",  1, 1, 3'd2, 0, 1, 0, -1, 8, 8);
      step(1);
      cmd_valid = 1'b0;
      wait_sb(40, "rr_rampup_timeout");
      step(3);
      mon_on  = 1'b0;
      s_rst_n = 1'b0;
      step(1);
      check("rr_outputs", 32'(obs()), 32'h0);
      check("rr_ready", 32'(cmd_ready), 32'h1);
      s_rst_n = 1'b1;
      step(2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/motor_seq_ctrl.md
# motor_seq_ctrl

Motion sequencer that drives the PWM motor driver's `enable`, `direct` and `cnt[2:0]` speed inputs. It accepts one motion command at a time: direction, target speed level and run duration. It soft-starts the motor by ramping speed one level at a time, holds the target speed for the commanded time, and ramps back down. It then enforces a coast-down dead time before accepting the next command. It sits between the command source (keypad/UART decoder) and the PWM driver, and guarantees the driver never sees a speed step larger than one level or a direction change while energised.

## Interface
- `TICK_DIV`, 50000: sclk cycles per time tick (1 ms at 50 MHz); must be ≥2.
- `RAMP_TICKS`, 20: ticks per one-level speed step; must be ≥1.
- `DEAD_TICKS`, 100: ticks of forced disable after every stop; must be ≥1.

- `sclk` in 1: system clock; all logic on the rising edge.
- `s_rst_n` in 1: synchronous, active-low reset.
- `cmd_valid` in 1: command present.
- `cmd_ready` out 1: command accepted when `cmd_valid & cmd_ready` at a rising edge.
- `cmd_dir` in 1: requested direction, maps to `pwm_direct`.
- `cmd_speed` in 3: target speed level, 0..7.
- `cmd_dur` in 16: run time in ticks at target speed; 0 means continuous.
- `stop_req` in 1: controlled stop (ramp down).
- `estop` in 1: emergency stop, level-sensitive, highest priority.
- `pwm_enable` out 1: to driver `enable`.
- `pwm_direct` out 1: to driver `direct`.
- `pwm_cnt` out 3: to driver `cnt`; equals current speed level.
- `busy` out 1: high in any state other than IDLE.
- `done` out 1: one-cycle pulse on normal completion.
- `fault` out 1: sticky flag, estop aborted a motion.

## Operation
- Tick prescaler is free-running from reset: it counts 0..TICK_DIV-1, and `tick` is high in the cycle where the count is TICK_DIV-1.
- Internal registers: `cur_speed[2:0]`, `tgt_speed[2:0]`, `dir_q`, `dur_cnt[15:0]`, `ramp_cnt`, `dead_cnt`.
- All outputs are registered. `pwm_cnt` equals `cur_speed` and `pwm_direct` equals `dir_q`.
- States: IDLE, RAMP_UP, RUN, RAMP_DOWN, DEAD.
- **IDLE**
  - `cmd_ready` is `~estop`; `pwm_enable` is 0; `cur_speed` is 0.
  - On accept with `cmd_speed` = 0: pulse `done` the next cycle, clear `fault`, stay in IDLE, and leave `dir_q` unchanged.
  - On accept with `cmd_speed` ≠ 0: latch `tgt_speed`, `dir_q` and `dur_cnt`; clear `fault` and `ramp_cnt`; go to RAMP_UP. `pwm_enable` = 1 from the next cycle.
  - `stop_req` is ignored.
- **RAMP_UP**
  - On each tick, `ramp_cnt` increments. On a tick where `ramp_cnt` = RAMP_TICKS-1, `ramp_cnt` resets to 0 and `cur_speed` increments.
  - When `cur_speed` = `tgt_speed`, go to RUN.
- **RUN**
  - `cur_speed` holds.
  - If `dur_cnt` ≠ 0: decrement on each tick. A tick with `dur_cnt` = 1 goes to RAMP_DOWN, giving exactly `cmd_dur` ticks in RUN.
  - If `dur_cnt` = 0 (continuous): stay in RUN until `stop_req`.
- **stop_req in RAMP_UP or RUN:** go to RAMP_DOWN next cycle, clear `ramp_cnt`, and keep `cur_speed` (no step).
- **RAMP_DOWN**
  - Same step cadence as RAMP_UP, but `cur_speed` decrements.
  - When `cur_speed` = 0, go to DEAD with `pwm_enable` = 0 and `dead_cnt` cleared.
- **DEAD**
  - `dead_cnt` increments on each tick.
  - On a tick with `dead_cnt` = DEAD_TICKS-1, go to IDLE. `done` pulses in the same cycle IDLE is entered, but only if the motion was not aborted.
- **estop**
  - Overrides everything in any busy state.
  - Next edge: `cur_speed` = 0, `pwm_enable` = 0, state = DEAD, `dead_cnt` = 0, `fault` = 1 (only if it was busy).
  - While `estop` is held, `dead_cnt` is held at 0.
  - No `done` is issued for an aborted motion.
- `cmd_valid` outside IDLE is ignored; the command is not queued.

## Timing
- Reset values:
  - State IDLE.
  - `cmd_ready` = 1 (if `estop` is low); `pwm_enable`, `pwm_direct`, `pwm_cnt`, `busy`, `done`, `fault` all 0.
  - Prescaler and all counters at 0.
- Reset mid-motion: all outputs return to reset values on the edge where `s_rst_n` is sampled low. There is no ramp-down.
- Accept to `pwm_enable` = 1: one cycle. First speed step: after RAMP_TICKS ticks. Tick phase is free-running, so the first step lands within RAMP_TICKS·TICK_DIV - TICK_DIV + 1 to RAMP_TICKS·TICK_DIV cycles.
- Speed changes by at most 1 per tick. `pwm_direct` changes only in IDLE, while `pwm_enable` = 0.
- Simultaneous events:
  - `estop` beats `stop_req`, which beats duration expiry, which beats a ramp step.
  - `stop_req` on the same edge that RAMP_UP reaches target goes to RAMP_DOWN.

## Test plan
Bench uses TICK_DIV=4, RAMP_TICKS=2, DEAD_TICKS=3.

1. **Reset.** Hold `s_rst_n` = 0 for 3 cycles. Expect all outputs 0, `cmd_ready` = 1. Then assert reset again mid-RUN: outputs must be 0 on the next edge.
2. **Normal move.** Command dir=1, speed=3, dur=5.
   - `pwm_enable`/`pwm_direct` go to 1 one cycle after accept.
   - `pwm_cnt` steps 1, 2, 3 at 8-cycle intervals, then holds 3 for exactly 20 cycles.
   - It then steps 2, 1, 0 every 8 cycles, with `pwm_enable` falling together with 0.
   - `done` pulses 12 cycles later; `busy` falls in the same cycle.
3. **Continuous run.** Command speed=7, dur=0; assert `stop_req` after 100 cycles. Expect ramp-down from the current level with no extra hold, then DEAD and `done`. Also pulse `stop_req` during RAMP_UP at level 2: expect the level to fall 2→1→0.
4. **Emergency stop.** Assert `estop` in RUN at speed 3 for 10 cycles.
   - Next edge: `pwm_cnt` = 0, `pwm_enable` = 0, `fault` = 1.
   - After release, IDLE is reached 12 cycles later with no `done`.
   - The next accepted command clears `fault`.
5. **Zero-speed command.** Command speed=0 in IDLE. Expect `done` next cycle, `pwm_enable` to stay 0, `busy` to stay 0, and `pwm_direct` unchanged.
6. **Handshake.** Hold `cmd_valid` high for the whole of test 2 with changing payloads. Only the first payload is used and `cmd_ready` = 0 while busy. `stop_req` in IDLE has no effect, and `cmd_ready` = 0 while `estop` is high in IDLE.
